// File: rtl/uart_transceiver_pkg.sv
// Shared UART constants: frame-format selectors, FSM state codes and the baud divisor helper.
package uart_transceiver_pkg;

    localparam int STOP_BITS_ONE = 0;
    localparam int STOP_BITS_TWO = 1;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clock cycles per bit; never below 2 so the half-bit start check stays meaningful.
    function automatic int calc_div(input int f_clk, input int baud);
        int d;
        d = f_clk / baud;
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/uart_transceiver_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rd_dat shows the head combinationally, zero when empty.
// Push while full is honoured only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    output logic                  full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign do_pop  = rd && !empty;
    assign do_push = wr && (!full || do_pop);
    assign rd_dat  = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver: FIFO-buffered TX and RX with configurable data width, parity and stop bits.
// TX frames start within 2 cycles of data; RX pushes one cycle after the stop sample.
module uart_transceiver
    import uart_transceiver_pkg::*;
#(
    parameter int F_CLK              = 100_000_000,
    parameter int BAUDRATE           = 115200,
    parameter int DATA_WIDTH         = 8,
    parameter int STOP_BITS          = STOP_BITS_ONE,
    parameter int PARITY             = PARITY_NONE,
    parameter int FIFO_TX_ADDR_WIDTH = 4,
    parameter int FIFO_RX_ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_tx_rdy,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_rx_valid,
    output logic [2:0]            o_err_state,
    output logic                  o_err
);
    localparam int              DIV       = calc_div(F_CLK, BAUDRATE);
    localparam int              CW        = $clog2(DIV + 1);
    localparam logic [CW-1:0]   DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam bit              HAS_PAR   = (PARITY != PARITY_NONE);
    localparam bit              ODD       = (PARITY == PARITY_ODD);
    localparam bit              STOP_LAST = (STOP_BITS == STOP_BITS_TWO);

    logic                  tx_full, tx_empty, tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;
    logic                  rx_full, rx_empty;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(FIFO_TX_ADDR_WIDTH)) u_tx_fifo (
        .clk(i_clk), .arst_n(i_arst_n), .wr(i_wr), .wr_dat(i_data), .full(tx_full),
        .rd(tx_pop), .rd_dat(tx_head), .empty(tx_empty)
    );

    logic [2:0]            tx_st_q, tx_st_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [3:0]            tx_idx_q, tx_idx_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_q, tx_d;
    logic                  tx_bit_end;

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_bit_end = (tx_cnt_q == DIV_LAST);
        tx_cnt_d   = (tx_st_q == ST_IDLE || tx_bit_end) ? '0 : tx_cnt_q + CW'(1);
        case (tx_st_q)
            ST_IDLE: if (!tx_empty) begin
                tx_pop   = 1'b1;
                tx_sh_d  = tx_head;
                tx_par_d = (^tx_head) ^ ODD;
                tx_st_d  = ST_START;
            end
            ST_START: if (tx_bit_end) begin
                tx_st_d  = ST_DATA;
                tx_idx_d = '0;
            end
            ST_DATA: if (tx_bit_end) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_idx_d = tx_idx_q + 4'd1;
                if (tx_idx_q == DATA_LAST) begin
                    tx_st_d  = HAS_PAR ? ST_PARITY : ST_STOP;
                    tx_idx_d = '0;
                end
            end
            ST_PARITY: if (tx_bit_end) tx_st_d = ST_STOP;
            ST_STOP: if (tx_bit_end) begin
                tx_idx_d = tx_idx_q + 4'd1;
                if (tx_idx_q[0] == STOP_LAST) begin
                    // Chain straight into the next frame when data is waiting: no idle gap.
                    if (!tx_empty) begin
                        tx_pop   = 1'b1;
                        tx_sh_d  = tx_head;
                        tx_par_d = (^tx_head) ^ ODD;
                        tx_st_d  = ST_START;
                    end else begin
                        tx_st_d  = ST_IDLE;
                    end
                end
            end
            default: tx_st_d = ST_IDLE;
        endcase
        case (tx_st_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_sh_d[0];
            ST_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    logic                  rx_s1_q, rx_s2_q, rx_s3_q;
    logic [2:0]            rx_st_q, rx_st_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [3:0]            rx_idx_q, rx_idx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic                  rx_push_q, rx_push_d;
    logic                  par_err, frm_err, ovf_err;
    logic [2:0]            err_state_q, err_state_d;
    logic                  err_q, err_d;

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_idx_d  = rx_idx_q;
        rx_sh_d   = rx_sh_q;
        rx_push_d = 1'b0;
        par_err   = 1'b0;
        frm_err   = 1'b0;
        rx_cnt_d  = (rx_st_q == ST_IDLE) ? '0 : rx_cnt_q + CW'(1);
        case (rx_st_q)
            ST_IDLE: if (rx_s3_q && !rx_s2_q) rx_st_d = ST_START;
            ST_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_WIDTH-1:1]};
                rx_idx_d = rx_idx_q + 4'd1;
                if (rx_idx_q == DATA_LAST) rx_st_d = HAS_PAR ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d = '0;
                par_err  = (rx_s2_q != ((^rx_sh_q) ^ ODD));
                rx_st_d  = ST_STOP;
            end
            ST_STOP: if (rx_cnt_q == DIV_LAST) begin
                // Only the first stop bit is checked; a second one reads as idle line.
                rx_st_d   = ST_IDLE;
                rx_push_d = rx_s2_q;
                frm_err   = !rx_s2_q;
            end
            default: rx_st_d = ST_IDLE;
        endcase
        ovf_err     = rx_push_q && rx_full && !i_rd;
        err_state_d = err_state_q | {ovf_err, frm_err, par_err};
        err_d       = ovf_err || frm_err || par_err;
    end

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(FIFO_RX_ADDR_WIDTH)) u_rx_fifo (
        .clk(i_clk), .arst_n(i_arst_n), .wr(rx_push_q), .wr_dat(rx_sh_q), .full(rx_full),
        .rd(i_rd), .rd_dat(o_data), .empty(rx_empty)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            tx_st_q     <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_sh_q     <= '0;
            tx_par_q    <= 1'b0;
            tx_q        <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_st_q     <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_idx_q    <= '0;
            rx_sh_q     <= '0;
            rx_push_q   <= 1'b0;
            err_state_q <= '0;
            err_q       <= 1'b0;
        end else begin
            tx_st_q     <= tx_st_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_sh_q     <= tx_sh_d;
            tx_par_q    <= tx_par_d;
            tx_q        <= tx_d;
            rx_s1_q     <= i_rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            rx_st_q     <= rx_st_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_sh_q     <= rx_sh_d;
            rx_push_q   <= rx_push_d;
            err_state_q <= err_state_d;
            err_q       <= err_d;
        end
    end

    assign o_tx        = tx_q;
    assign o_tx_rdy    = !tx_full;
    assign o_rx_valid  = !rx_empty;
    assign o_err_state = err_state_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: DIV=14, odd parity, one stop bit; loopback and directly driven frames.
module tb_uart_transceiver;
    import uart_transceiver_pkg::*;

    localparam int DIV   = 14;
    localparam int FRAME = 11 * DIV;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       loop = 1'b1;
    logic       tb_rx = 1'b1;
    logic       rx_line;
    logic       o_tx, o_tx_rdy, o_rx_valid, o_err;
    logic       i_wr = 1'b0, i_rd = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [7:0] o_data;
    logic [2:0] o_err_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int err_cyc = 0;

    logic [7:0] mon_dat [$];
    logic       mon_par [$];
    int         mon_t   [$];
    logic [7:0] exp_q   [$];

    assign rx_line = loop ? o_tx : tb_rx;

    uart_transceiver #(
        .F_CLK(166_666_667), .BAUDRATE(11_520_000), .DATA_WIDTH(8),
        .STOP_BITS(STOP_BITS_ONE), .PARITY(PARITY_ODD),
        .FIFO_TX_ADDR_WIDTH(4), .FIFO_RX_ADDR_WIDTH(4)
    ) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_rx(rx_line), .o_tx(o_tx),
        .i_wr(i_wr), .i_data(i_data), .o_tx_rdy(o_tx_rdy), .i_rd(i_rd),
        .o_data(o_data), .o_rx_valid(o_rx_valid), .o_err_state(o_err_state), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (o_err === 1'b1) err_cyc <= err_cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Odd parity: the bit that makes the total number of ones odd.
    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Independent line decoder on o_tx: records data, parity bit and start time per frame.
    initial begin : tx_monitor
        logic [7:0] d;
        logic       p;
        int         t;
        forever begin
            @(negedge clk);
            if (arst_n === 1'b1 && o_tx === 1'b0) begin
                t = cyc;
                repeat (DIV / 2) @(negedge clk);
                if (o_tx !== 1'b0) continue;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    d[i] = o_tx;
                end
                repeat (DIV) @(negedge clk);
                p = o_tx;
                repeat (DIV) @(negedge clk);
                mon_dat.push_back(d);
                mon_par.push_back(p);
                mon_t.push_back(t);
            end
        end
    end

    task automatic write_byte(input logic [7:0] d);
        i_wr = 1'b1;
        i_data = d;
        @(posedge clk); #1;
        i_wr = 1'b0;
    endtask

    task automatic read_byte();
        i_rd = 1'b1;
        @(posedge clk); #1;
        i_rd = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int waited);
        waited = 0;
        while (o_rx_valid !== 1'b1 && waited < maxc) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_timeout"}, 32'(waited < maxc), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_val);
        logic [10:0] bits;
        bits = {stop_val, odd_par(d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            tb_rx = bits[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        tb_rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"},     32'(o_tx), 32'd1);
        check({tag, "_rdy"},    32'(o_tx_rdy), 32'd1);
        check({tag, "_valid"},  32'(o_rx_valid), 32'd0);
        check({tag, "_data"},   32'(o_data), 32'd0);
        check({tag, "_errst"},  32'(o_err_state), 32'd0);
        check({tag, "_err"},    32'(o_err), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : main
        int w, e0;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        arst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single loopback byte with latency window around one frame time.
        write_byte(8'hA5);
        wait_valid("a5", 400, w);
        check("a5_latency_window", 32'(w >= FRAME - 14 && w <= FRAME + 16), 32'd1);
        check("a5_data", 32'(o_data), 32'hA5);
        check("a5_errst", 32'(o_err_state), 32'd0);
        read_byte();
        check("a5_empty", 32'(o_rx_valid), 32'd0);

        // Back-to-back 0x00 / 0xFF: parity bits, no inter-frame gap, in-order data.
        repeat (20) @(posedge clk);
        #1;
        mon_dat.delete(); mon_par.delete(); mon_t.delete();
        write_byte(8'h00);
        write_byte(8'hFF);
        wait_valid("b2b0", 400, w);
        check("b2b_first", 32'(o_data), 32'h00);
        read_byte();
        wait_valid("b2b1", 400, w);
        check("b2b_second", 32'(o_data), 32'hFF);
        read_byte();
        check("b2b_empty", 32'(o_rx_valid), 32'd0);
        w = 0;
        while (mon_t.size() < 2 && w < 400) begin
            @(posedge clk); #1; w++;
        end
        check("b2b_mon_frames", 32'(mon_t.size() >= 2), 32'd1);
        if (mon_t.size() >= 2) begin
            check("b2b_par_00", 32'(mon_par[0]), 32'(odd_par(8'h00)));
            check("b2b_par_ff", 32'(mon_par[1]), 32'(odd_par(8'hFF)));
            check("b2b_gap", 32'(mon_t[1] - mon_t[0]), 32'(FRAME));
        end

        // Random bytes through the loopback against an in-order queue model.
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            write_byte(b);
        end
        for (int i = 0; i < 8; i++) begin
            wait_valid("rnd", 2 * FRAME + 50, w);
            check("rnd_data", 32'(o_data), 32'(exp_q.pop_front()));
            read_byte();
        end
        check("rnd_errst", 32'(o_err_state), 32'd0);

        // Inverted parity bit: flagged, pulsed once, byte still stored.
        loop = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        e0 = err_cyc;
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_valid("par", 60, w);
        repeat (5) @(posedge clk);
        #1;
        check("par_pulse_cycles", 32'(err_cyc - e0), 32'd1);
        check("par_errst", 32'(o_err_state), 32'b001);
        check("par_data", 32'(o_data), 32'h3C);
        read_byte();

        // Stop bit 0: framing flag, nothing stored.
        e0 = err_cyc;
        send_frame(8'h96, 1'b0, 1'b0);
        repeat (2 * DIV) @(posedge clk);
        #1;
        check("frm_errst", 32'(o_err_state), 32'b011);
        check("frm_valid", 32'(o_rx_valid), 32'd0);
        check("frm_pulse_cycles", 32'(err_cyc - e0), 32'd1);

        // Fill TX FIFO, overflow RX FIFO by one byte.
        arst_n = 1'b0;
        #1;
        check("rst2_errst", 32'(o_err_state), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        loop = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mon_dat.delete(); mon_par.delete(); mon_t.delete();
        exp_q.delete();
        // One byte leaves for the shifter immediately, so DEPTH+1 writes fill the FIFO.
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            check("fill_rdy", 32'(o_tx_rdy), 32'd1);
            write_byte(b);
        end
        check("fill_full", 32'(o_tx_rdy), 32'd0);
        write_byte(8'hEE);
        e0 = err_cyc;
        repeat ((DEPTH + 1) * FRAME + 200) @(posedge clk);
        #1;
        check("fill_tx_frames", 32'(mon_dat.size()), 32'(DEPTH + 1));
        check("ovf_errst", 32'(o_err_state), 32'b100);
        check("ovf_pulse_cycles", 32'(err_cyc - e0), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("ovf_valid", 32'(o_rx_valid), 32'd1);
            check("ovf_data", 32'(o_data), 32'(exp_q[i]));
            read_byte();
        end
        check("ovf_dropped", 32'(o_rx_valid), 32'd0);

        // Reset in the middle of a loopback frame.
        write_byte(8'h77);
        repeat (60) @(posedge clk);
        #1;
        arst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_partial", 32'(o_rx_valid), 32'd0);
        write_byte(8'h5A);
        wait_valid("post_rst", 400, w);
        check("post_rst_data", 32'(o_data), 32'h5A);
        check("post_rst_errst", 32'(o_err_state), 32'd0);
        read_byte();
        check("post_rst_empty", 32'(o_rx_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
